// File: rtl/bus_req_master.sv
// bus_req_master: queues client burst commands, requests the shared bus from
// the arbiter, and once granted drives the burst beats. It also keeps
// issue/beat counters and a sticky grant-timeout flag.
module bus_req_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              request,
  input  logic              grant,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_last,
  output logic              busy,
  output logic              timeout_err,
  output logic [31:0]       issued_count,
  output logic [31:0]       beat_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [LEN_W-1:0]  r_mem_len  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_occ;
  logic [CNT_W-1:0]  w_occ_next;
  logic              r_cmd_ready;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_enter_req;
  logic              w_wait_inc;
  logic              w_beat_adv;
  logic              w_burst_end;

  logic [ADDR_W-1:0] w_head_addr;
  logic [LEN_W-1:0]  w_head_len;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic [LEN_W-1:0]  w_beat_nxt;
  logic [WAIT_W-1:0] r_wait;

  logic              r_request;
  logic              r_bus_valid;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_last;
  logic              r_timeout_err;
  logic [31:0]       r_issued;
  logic [31:0]       r_beats;

  // cmd_ready is a registered copy of !full, so it is 0 during reset and a
  // push is refused while full even if a pop happens in the same cycle.
  assign w_push      = cmd_valid && r_cmd_ready;
  assign w_empty     = (r_occ == '0);
  assign w_head_addr = r_mem_addr[r_rd_ptr];
  assign w_head_len  = r_mem_len[r_rd_ptr];
  assign w_beat_nxt  = r_beat + 1'b1;

  assign cmd_ready    = r_cmd_ready;
  assign request      = r_request;
  assign bus_valid    = r_bus_valid;
  assign bus_addr     = r_bus_addr;
  assign bus_last     = r_bus_last;
  assign timeout_err  = r_timeout_err;
  assign issued_count = r_issued;
  assign beat_count   = r_beats;
  assign busy         = (r_state != S_IDLE) || !w_empty;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    w_occ_next = r_occ;
    if (w_push && !w_pop) begin
      w_occ_next = r_occ + 1'b1;
    end else if (!w_push && w_pop) begin
      w_occ_next = r_occ - 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= cmd_addr;
      r_mem_len[r_wr_ptr]  <= cmd_len;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ       <= w_occ_next;
      r_cmd_ready <= (w_occ_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and control strobes; grant only matters while in REQ, so a
  // lagging grant after request falls is ignored.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_enter_req  = 1'b0;
    w_wait_inc   = 1'b0;
    w_beat_adv   = 1'b0;
    w_burst_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next = S_REQ;
          w_enter_req  = 1'b1;
        end
      end
      S_REQ: begin
        if (grant) begin
          w_pop        = 1'b1;
          w_state_next = S_XFER;
        end else begin
          w_wait_inc   = 1'b1;
        end
      end
      S_XFER: begin
        if (r_bus_last) begin
          w_burst_end  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_beat_adv   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request, wait/timeout tracking, beat generation and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_request     <= 1'b0;
      r_wait        <= '0;
      r_timeout_err <= 1'b0;
      r_base        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_bus_valid   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_last    <= 1'b0;
      r_issued      <= '0;
      r_beats       <= '0;
    end else begin
      if (w_enter_req) begin
        r_request <= 1'b1;
        r_wait    <= '0;
      end
      if (w_wait_inc) begin
        // Saturate at TIMEOUT; the flag is sticky and the request is held.
        if (r_wait != WAIT_W'(TIMEOUT)) r_wait <= r_wait + 1'b1;
        if (r_wait == WAIT_W'(TIMEOUT - 1)) r_timeout_err <= 1'b1;
      end
      if (w_pop) begin
        // The first beat is presented straight from the FIFO head so it is
        // valid the cycle after grant is sampled.
        r_request   <= 1'b0;
        r_base      <= w_head_addr;
        r_len       <= w_head_len;
        r_beat      <= '0;
        r_bus_valid <= 1'b1;
        r_bus_addr  <= w_head_addr;
        r_bus_last  <= (w_head_len == '0);
        r_issued    <= r_issued + 1'b1;
      end
      if (w_beat_adv) begin
        r_beat     <= w_beat_nxt;
        r_bus_addr <= r_base + (ADDR_W'(w_beat_nxt) << 2);
        r_bus_last <= (w_beat_nxt == r_len);
      end
      if (w_burst_end) begin
        r_bus_valid <= 1'b0;
        r_bus_last  <= 1'b0;
        r_bus_addr  <= '0;
      end
      if (w_beat_adv || w_burst_end) begin
        r_beats <= r_beats + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_req_master.sv
// Directed testbench for bus_req_master: single burst, FIFO full handling,
// grant timeout, lingering grant, address wrap and mid-burst reset.
module tb_bus_req_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        request;
  logic        grant;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic        bus_last;
  logic        busy;
  logic        timeout_err;
  logic [31:0] issued_count;
  logic [31:0] beat_count;

  int checks = 0;
  int passed = 0;
  int exp_issued = 0;
  int exp_beats = 0;

  logic        arb_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] beat_q[$];
  logic        last_q[$];

  bus_req_master #(
    .FIFO_DEPTH(4), .ADDR_W(32), .LEN_W(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .request(request), .grant(grant),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_last(bus_last),
    .busy(busy), .timeout_err(timeout_err),
    .issued_count(issued_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, log any beat on the bus, and model the
  // arbiter: grant this cycle equals request from the previous cycle.
  task automatic step();
    @(negedge clk);
    if (bus_valid) begin
      beat_q.push_back(bus_addr);
      last_q.push_back(bus_last);
      $display("beat  addr=%08h last=%b", bus_addr, bus_last);
    end
    grant = arb_en ? prev_req : 1'b0;
    prev_req = request;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; grant = 1'b0;
    @(negedge clk);
    checks++; if ({cmd_ready, request, bus_valid, bus_last, busy, timeout_err} !== 6'b0) $display("FAIL reset_flags: got %b want 000000", {cmd_ready, request, bus_valid, bus_last, busy, timeout_err}); else passed++;
    checks++; if (bus_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus_addr); else passed++;
    checks++; if ({issued_count, beat_count} !== 64'h0) $display("FAIL reset_counts: got %0d/%0d want 0/0", issued_count, beat_count); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else passed++;
    $display("reset done");
  endtask

  task automatic test_single_burst();
    logic [31:0] exp_a [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    arb_en = 1'b1; beat_q.delete(); last_q.delete();
    cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_len = 4'd3;
    step();
    cmd_valid = 1'b0;
    checks++; if (request !== 1'b0 || busy !== 1'b1) $display("FAIL single_pre_req: request=%b busy=%b want 0/1", request, busy); else passed++;
    step();
    checks++; if (request !== 1'b1) $display("FAIL single_req_rise: got %b want 1", request); else passed++;
    for (int i = 0; i < 10; i++) step();
    checks++; if (beat_q.size() !== 4) $display("FAIL single_nbeats: got %0d want 4", beat_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a; logic l;
      a = (i < beat_q.size()) ? beat_q[i] : 32'hx;
      l = (i < last_q.size()) ? last_q[i] : 1'bx;
      checks++; if (a !== exp_a[i] || l !== (i == 3)) $display("FAIL single_beat%0d: got %h/%b want %h/%b", i, a, l, exp_a[i], (i == 3)); else passed++;
    end
    exp_issued += 1; exp_beats += 4;
    checks++; if (issued_count !== 32'(exp_issued) || beat_count !== 32'(exp_beats)) $display("FAIL single_counts: got %0d/%0d want %0d/%0d", issued_count, beat_count, exp_issued, exp_beats); else passed++;
    checks++; if (busy !== 1'b0 || request !== 1'b0) $display("FAIL single_idle: busy=%b request=%b want 0/0", busy, request); else passed++;
  endtask

  task automatic test_fifo_full();
    arb_en = 1'b0; beat_q.delete(); last_q.delete();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_addr = 32'h5000 + 32'(i * 16); cmd_len = 4'd0;
      checks++; if (cmd_ready !== (i < 4)) $display("FAIL full_ready%0d: got %b want %b", i, cmd_ready, (i < 4)); else passed++;
      $display("push%0d addr=%08h ready=%b", i, cmd_addr, cmd_ready);
      step();
    end
    checks++; if (cmd_ready !== 1'b0 || request !== 1'b1) $display("FAIL full_hold: ready=%b request=%b want 0/1", cmd_ready, request); else passed++;
    step();
    grant = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", cmd_ready); else passed++;
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h5000) $display("FAIL full_first_beat: got %b/%h want 1/00005000", bus_valid, bus_addr); else passed++;
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL full_fifth_accepted: ready=%b want 0", cmd_ready); else passed++;
    arb_en = 1'b1;
    for (int i = 0; i < 30; i++) step();
    checks++; if (beat_q.size() !== 5) $display("FAIL full_nbeats: got %0d want 5", beat_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] a; logic l;
      a = (i < beat_q.size()) ? beat_q[i] : 32'hx;
      l = (i < last_q.size()) ? last_q[i] : 1'bx;
      checks++; if (a !== 32'h5000 + 32'(i * 16) || l !== 1'b1) $display("FAIL full_beat%0d: got %h/%b want %h/1", i, a, l, 32'h5000 + 32'(i * 16)); else passed++;
    end
    exp_issued += 5; exp_beats += 5;
    checks++; if (issued_count !== 32'(exp_issued) || beat_count !== 32'(exp_beats)) $display("FAIL full_counts: got %0d/%0d want %0d/%0d", issued_count, beat_count, exp_issued, exp_beats); else passed++;
  endtask

  task automatic test_timeout();
    arb_en = 1'b0; beat_q.delete(); last_q.delete();
    cmd_valid = 1'b1; cmd_addr = 32'h2000; cmd_len = 4'd1;
    step();
    cmd_valid = 1'b0;
    for (int i = 2; i <= 256; i++) step();
    checks++; if (timeout_err !== 1'b0 || request !== 1'b1) $display("FAIL timeout_early: err=%b request=%b want 0/1", timeout_err, request); else passed++;
    step();
    checks++; if (timeout_err !== 1'b1 || request !== 1'b1) $display("FAIL timeout_set: err=%b request=%b want 1/1", timeout_err, request); else passed++;
    for (int i = 0; i < 43; i++) step();
    checks++; if (timeout_err !== 1'b1 || request !== 1'b1 || bus_valid !== 1'b0) $display("FAIL timeout_hold: err=%b request=%b valid=%b want 1/1/0", timeout_err, request, bus_valid); else passed++;
    arb_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (beat_q.size() !== 2) $display("FAIL timeout_nbeats: got %0d want 2", beat_q.size()); else passed++;
    if (beat_q.size() == 2) begin
      checks++; if (beat_q[0] !== 32'h2000 || beat_q[1] !== 32'h2004 || last_q[0] !== 1'b0 || last_q[1] !== 1'b1) $display("FAIL timeout_beats: got %h/%b %h/%b want 00002000/0 00002004/1", beat_q[0], last_q[0], beat_q[1], last_q[1]); else passed++;
    end
    exp_issued += 1; exp_beats += 2;
    checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", timeout_err); else passed++;
    checks++; if (issued_count !== 32'(exp_issued) || beat_count !== 32'(exp_beats)) $display("FAIL timeout_counts: got %0d/%0d want %0d/%0d", issued_count, beat_count, exp_issued, exp_beats); else passed++;
  endtask

  task automatic test_grant_hold();
    arb_en = 1'b0;
    cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 4'd0;
    step();
    cmd_addr = 32'h3010;
    step();
    cmd_valid = 1'b0;
    checks++; if (request !== 1'b1) $display("FAIL hold_req: got %b want 1", request); else passed++;
    step(); grant = 1'b1;
    step(); grant = 1'b1;
    exp_issued += 1;
    checks++; if (request !== 1'b0 || bus_valid !== 1'b1 || bus_addr !== 32'h3000) $display("FAIL hold_first: req=%b valid=%b addr=%h want 0/1/00003000", request, bus_valid, bus_addr); else passed++;
    step(); grant = 1'b1;
    checks++; if (request !== 1'b0 || bus_valid !== 1'b0) $display("FAIL hold_lingering: req=%b valid=%b want 0/0", request, bus_valid); else passed++;
    step(); grant = 1'b0;
    checks++; if (request !== 1'b1 || bus_valid !== 1'b0 || issued_count !== 32'(exp_issued)) $display("FAIL hold_rereq: req=%b valid=%b issued=%0d want 1/0/%0d", request, bus_valid, issued_count, exp_issued); else passed++;
    step(); grant = 1'b1;
    checks++; if (bus_valid !== 1'b0) $display("FAIL hold_no_second: valid=%b want 0", bus_valid); else passed++;
    step(); grant = 1'b0;
    exp_issued += 1; exp_beats += 2;
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h3010 || issued_count !== 32'(exp_issued)) $display("FAIL hold_second: valid=%b addr=%h issued=%0d want 1/00003010/%0d", bus_valid, bus_addr, issued_count, exp_issued); else passed++;
    step();
    checks++; if (busy !== 1'b0 || beat_count !== 32'(exp_beats)) $display("FAIL hold_done: busy=%b beats=%0d want 0/%0d", busy, beat_count, exp_beats); else passed++;
  endtask

  task automatic test_addr_wrap();
    arb_en = 1'b1; beat_q.delete(); last_q.delete();
    cmd_valid = 1'b1; cmd_addr = 32'hFFFF_FFFC; cmd_len = 4'd1;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (beat_q.size() !== 2) $display("FAIL wrap_nbeats: got %0d want 2", beat_q.size()); else passed++;
    if (beat_q.size() == 2) begin
      checks++; if (beat_q[0] !== 32'hFFFF_FFFC || beat_q[1] !== 32'h0 || last_q[1] !== 1'b1 || last_q[0] !== 1'b0) $display("FAIL wrap_beats: got %h/%b %h/%b want fffffffc/0 00000000/1", beat_q[0], last_q[0], beat_q[1], last_q[1]); else passed++;
    end
    exp_issued += 1; exp_beats += 2;
    checks++; if (issued_count !== 32'(exp_issued) || beat_count !== 32'(exp_beats)) $display("FAIL wrap_counts: got %0d/%0d want %0d/%0d", issued_count, beat_count, exp_issued, exp_beats); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    arb_en = 1'b1; beat_q.delete(); last_q.delete();
    cmd_valid = 1'b1; cmd_addr = 32'h4000; cmd_len = 4'd3;
    step();
    cmd_addr = 32'h4100; cmd_len = 4'd0;
    step();
    cmd_addr = 32'h4200;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h4008) $display("FAIL mid_beat2: valid=%b addr=%h want 1/00004008", bus_valid, bus_addr); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, request, bus_valid, bus_last, busy, timeout_err} !== 6'b0 || bus_addr !== 32'h0) $display("FAIL mid_async_outputs: flags=%b addr=%h want 000000/0", {cmd_ready, request, bus_valid, bus_last, busy, timeout_err}, bus_addr); else passed++;
    checks++; if ({issued_count, beat_count} !== 64'h0) $display("FAIL mid_async_counts: got %0d/%0d want 0/0", issued_count, beat_count); else passed++;
    arb_en = 1'b0;
    step(); step();
    rst_n = 1'b1;
    beat_q.delete(); last_q.delete();
    arb_en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++; if (request !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || beat_q.size() !== 0) $display("FAIL mid_after_release: req=%b busy=%b ready=%b beats_seen=%0d want 0/0/1/0", request, busy, cmd_ready, beat_q.size()); else passed++;
    checks++; if ({issued_count, beat_count} !== 64'h0) $display("FAIL mid_after_counts: got %0d/%0d want 0/0", issued_count, beat_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fifo_full();
    test_timeout();
    test_grant_hold();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
